// File: rtl/floating_point_accumulator_pkg.sv
// Shared definitions for the floating-point accumulator: controller states,
// default float geometry and helpers for the special-value bit patterns.
package floating_point_accumulator_pkg;

    localparam int DEF_EXPONENT_WIDTH  = 8;
    localparam int DEF_MANTISSA_WIDTH  = 23;
    localparam int DEF_FLOAT_BIT_WIDTH = DEF_EXPONENT_WIDTH + DEF_MANTISSA_WIDTH + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    function automatic int float_bit_width(input int e, input int m);
        return e + m + 1;
    endfunction

    // Canonical quiet NaN: sign=1, exponent all ones, fraction MSB set.
    // The set bits run contiguously from the fraction MSB up to the sign bit.
    function automatic logic [127:0] qnan_pattern(input int e, input int m);
        return ((128'd1 << (e + 2)) - 128'd1) << (m - 1);
    endfunction

    localparam logic [DEF_FLOAT_BIT_WIDTH-1:0] POS_ZERO = '0;
    localparam logic [DEF_FLOAT_BIT_WIDTH-1:0] QNAN     =
        DEF_FLOAT_BIT_WIDTH'(qnan_pattern(DEF_EXPONENT_WIDTH, DEF_MANTISSA_WIDTH));

endpackage

// File: rtl/floating_point_accumulator_adder.sv
// Combinational IEEE-754 adder/subtractor, round-to-nearest-even, subnormal aware.
// NaN in -> canonical QNaN; invalid on Inf-Inf or signalling NaN; underflow on a tiny non-zero result.
module floating_point_adder
    import floating_point_accumulator_pkg::*;
#(
    parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] i_a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] i_b,
    input  logic                                   i_subtract,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] o_result,
    output logic                                   o_underflow,
    output logic                                   o_overflow,
    output logic                                   o_invalid
);
    localparam int E   = EXPONENT_WIDTH;
    localparam int M   = MANTISSA_WIDTH;
    localparam int FBW = float_bit_width(E, M);
    localparam int MW  = M + 4;  // hidden bit + fraction + guard/round/sticky
    localparam logic [FBW-1:0] QNAN_V  = FBW'(qnan_pattern(E, M));
    localparam logic [E+1:0]   EXP_MAX = {2'b00, {E{1'b1}}};
    localparam logic [E+1:0]   EXP_ONE = {{(E+1){1'b0}}, 1'b1};

    logic         w_sa, w_sb, w_sg, w_swap, w_hidden, w_rnd_up;
    logic [E-1:0] w_ea, w_eb, w_eg_raw, w_es_raw, w_eg, w_es, w_diff;
    logic [M-1:0] w_ma, w_mb, w_mg_raw, w_ms_raw, w_frac;
    logic         w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_snan, w_b_snan;
    int           w_shamt;
    logic [MW-1:0]   w_big, w_small, w_mn;
    logic [2*MW-1:0] w_align;
    logic [MW:0]     w_sum;
    logic [M+1:0]    w_rnd;
    logic [E+1:0]    w_en;

    assign w_sa = i_a[FBW-1];
    assign w_ea = i_a[FBW-2:M];
    assign w_ma = i_a[M-1:0];
    assign w_sb = i_b[FBW-1] ^ i_subtract;
    assign w_eb = i_b[FBW-2:M];
    assign w_mb = i_b[M-1:0];

    assign w_a_nan  = (&w_ea) & (|w_ma);
    assign w_b_nan  = (&w_eb) & (|w_mb);
    assign w_a_inf  = (&w_ea) & ~(|w_ma);
    assign w_b_inf  = (&w_eb) & ~(|w_mb);
    assign w_a_snan = w_a_nan & ~w_ma[M-1];
    assign w_b_snan = w_b_nan & ~w_mb[M-1];

    always_comb begin
        // Order operands by magnitude so the mantissa path only ever subtracts small from big.
        w_swap   = {w_eb, w_mb} > {w_ea, w_ma};
        w_sg     = w_swap ? w_sb : w_sa;
        w_eg_raw = w_swap ? w_eb : w_ea;
        w_mg_raw = w_swap ? w_mb : w_ma;
        w_es_raw = w_swap ? w_ea : w_eb;
        w_ms_raw = w_swap ? w_ma : w_mb;
        w_eg     = (w_eg_raw == '0) ? {{(E-1){1'b0}}, 1'b1} : w_eg_raw;
        w_es     = (w_es_raw == '0) ? {{(E-1){1'b0}}, 1'b1} : w_es_raw;
        w_diff   = w_eg - w_es;
        w_shamt  = (int'(w_diff) > MW) ? MW : int'(w_diff);

        w_big   = {|w_eg_raw, w_mg_raw, 3'b000};
        w_align = {|w_es_raw, w_ms_raw, 3'b000, {MW{1'b0}}} >> w_shamt;
        w_small = w_align[2*MW-1:MW] | {{(MW-1){1'b0}}, |w_align[MW-1:0]};
        w_sum   = (w_sa ^ w_sb) ? ({1'b0, w_big} - {1'b0, w_small})
                                : ({1'b0, w_big} + {1'b0, w_small});

        w_en = {2'b00, w_eg};
        w_mn = w_sum[MW-1:0];
        if (w_sum[MW]) begin
            w_mn = {w_sum[MW:2], w_sum[1] | w_sum[0]};
            w_en = w_en + 1'b1;
        end else begin
            // Left-normalise, but never below the minimum exponent (subnormal result).
            for (int k = 0; k < MW; k++) begin
                if (!w_mn[MW-1] && (w_en > EXP_ONE)) begin
                    w_mn = w_mn << 1;
                    w_en = w_en - 1'b1;
                end
            end
        end

        w_rnd_up = w_mn[2] & (w_mn[1] | w_mn[0] | w_mn[3]);
        w_rnd    = {1'b0, w_mn[MW-1:3]} + {{(M+1){1'b0}}, w_rnd_up};
        w_frac   = w_rnd[M-1:0];
        w_hidden = w_rnd[M];
        if (w_rnd[M+1]) begin
            w_en     = w_en + 1'b1;
            w_frac   = '0;
            w_hidden = 1'b1;
        end

        o_result    = {w_sg, (w_hidden ? w_en[E-1:0] : {E{1'b0}}), w_frac};
        o_underflow = 1'b0;
        o_overflow  = 1'b0;
        o_invalid   = 1'b0;
        if (w_a_nan || w_b_nan) begin
            o_result  = QNAN_V;
            o_invalid = w_a_snan | w_b_snan;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            o_result  = QNAN_V;
            o_invalid = 1'b1;
        end else if (w_a_inf) begin
            o_result = {w_sa, {E{1'b1}}, {M{1'b0}}};
        end else if (w_b_inf) begin
            o_result = {w_sb, {E{1'b1}}, {M{1'b0}}};
        end else if (w_sum == '0) begin
            o_result = {w_sa & w_sb, {(FBW-1){1'b0}}};
        end else if (w_en >= EXP_MAX) begin
            o_result   = {w_sg, {E{1'b1}}, {M{1'b0}}};
            o_overflow = 1'b1;
        end else begin
            o_underflow = ~w_hidden;
        end
    end
endmodule

// File: rtl/floating_point_accumulator.sv
// Folds a valid/ready operand frame into a running FP sum; result valid 1 cycle after the last beat.
// While the result waits for out_ready the input stream is stalled (in_ready=0) and out_* hold.
module floating_point_accumulator
    import floating_point_accumulator_pkg::*;
#(
    parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
    input  logic                                   in_subtract,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data,
    output logic [COUNT_WIDTH-1:0]                 out_count,
    output logic                                   underflow_flag,
    output logic                                   overflow_flag,
    output logic                                   invalid_operation_flag
);
    localparam int FBW = float_bit_width(EXPONENT_WIDTH, MANTISSA_WIDTH);

    acc_state_t             r_state;
    logic [FBW-1:0]         r_acc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_uf, r_of, r_inv;
    logic [FBW-1:0]         w_sum;
    logic                   w_uf, w_of, w_inv;

    floating_point_adder #(
        .EXPONENT_WIDTH(EXPONENT_WIDTH),
        .MANTISSA_WIDTH(MANTISSA_WIDTH)
    ) u_adder (
        .i_a        (r_acc),
        .i_b        (in_data),
        .i_subtract (in_subtract),
        .o_result   (w_sum),
        .o_underflow(w_uf),
        .o_overflow (w_of),
        .o_invalid  (w_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_uf    <= 1'b0;
            r_of    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_sum;
                        r_uf  <= r_uf | w_uf;
                        r_of  <= r_of | w_of;
                        r_inv <= r_inv | w_inv;
                        if (r_count != {COUNT_WIDTH{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (in_last) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Accumulator is cleared on the handshake edge so the next frame starts from +0.
                    if (out_ready) begin
                        r_state <= ACCUM;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_uf    <= 1'b0;
                        r_of    <= 1'b0;
                        r_inv   <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign in_ready               = (r_state == ACCUM);
    assign out_valid              = (r_state == HOLD);
    assign out_data               = r_acc;
    assign out_count              = r_count;
    assign underflow_flag         = r_uf;
    assign overflow_flag          = r_of;
    assign invalid_operation_flag = r_inv;
endmodule

// File: tb/tb_floating_point_accumulator.sv
// Table-driven frames checked through an output scoreboard, plus stall, reset and saturation sequences.
module tb_floating_point_accumulator;

    typedef struct {
        logic [31:0] d;
        logic        sub;
        logic        last;
        logic [31:0] exp_d;
        logic [15:0] exp_cnt;
        logic [2:0]  exp_flg;   // {underflow, overflow, invalid}
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [15:0] cnt;
        logic [2:0]  flg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_subtract, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        uf, of, inv;

    logic        in_valid2, in_ready2, in_last2;
    logic [31:0] in_data2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [3:0]  out_count2;
    logic        uf2, of2, inv2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    floating_point_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_subtract(in_subtract), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .underflow_flag(uf), .overflow_flag(of),
        .invalid_operation_flag(inv)
    );

    floating_point_accumulator #(.COUNT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .in_subtract(1'b0), .in_last(in_last2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .out_count(out_count2), .underflow_flag(uf2), .overflow_flag(of2),
        .invalid_operation_flag(inv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic sub, input logic last,
                                input logic [31:0] ed, input logic [15:0] ec, input logic [2:0] ef);
        vec_t v;
        v.d = d; v.sub = sub; v.last = last; v.exp_d = ed; v.exp_cnt = ec; v.exp_flg = ef;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] d, input logic [15:0] c, input logic [2:0] f);
        exp_t e;
        e.d = d; e.cnt = c; e.flg = f;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge right after the beat was taken.
    task automatic send(input logic [31:0] d, input logic sub, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_subtract = sub; in_last = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data 0x%08h, required no output", out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_count", {16'h0, out_count}, {16'h0, e.cnt});
                chk("out_flags", {29'h0, uf, of, inv}, {29'h0, e.flg});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_subtract = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0;

        vecs.push_back(mk(32'h40400000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h40800000, 0, 1, 32'h40E00000, 2, 3'b000));
        vecs.push_back(mk(32'h410B3333, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h3E99999A, 0, 1, 32'h41100000, 2, 3'b000));
        vecs.push_back(mk(32'h7F800000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h7F800000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(32'h40400000, 0, 1, 32'hFFC00000, 3, 3'b001));
        vecs.push_back(mk(32'h80000000, 0, 1, 32'h00000000, 1, 3'b000));
        vecs.push_back(mk(32'h3F800000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h3F800000, 1, 1, 32'h00000000, 2, 3'b000));
        vecs.push_back(mk(32'h7F7FFFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h7F7FFFFF, 0, 1, 32'h7F800000, 2, 3'b010));
        vecs.push_back(mk(32'h7FC00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h3F800000, 0, 1, 32'hFFC00000, 2, 3'b000));
        vecs.push_back(mk(32'h00800000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00400000, 1, 1, 32'h00400000, 2, 3'b100));
        vecs.push_back(mk(32'h3F800000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h40400000, 1, 1, 32'hC0000000, 2, 3'b000));
        vecs.push_back(mk(32'h3F800000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h33800000, 0, 1, 32'h3F800000, 2, 3'b000));
        vecs.push_back(mk(32'h3F800001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h33800000, 0, 1, 32'h3F800002, 2, 3'b000));

        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_count", {16'h0, out_count}, 32'h0);
        chk("reset_flags", {29'h0, uf, of, inv}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if (vecs[i].last) sb_q.push_back(mk_exp(vecs[i].exp_d, vecs[i].exp_cnt, vecs[i].exp_flg));
            send(vecs[i].d, vecs[i].sub, vecs[i].last);
            if (vecs[i].last) chk("latency_out_valid", {31'h0, out_valid}, 32'h1);
        end

        // Result stalled in HOLD: outputs must hold and the input stream must be blocked.
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        sb_q.push_back(mk_exp(32'hFFC00000, 3, 3'b001));
        send(32'h7F800000, 0, 0);
        send(32'h7F800000, 1, 0);
        send(32'h40400000, 0, 1);
        in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_out_data", out_data, 32'hFFC00000);
            chk("stall_out_count", {16'h0, out_count}, 32'h3);
            chk("stall_flags", {29'h0, uf, of, inv}, 32'h1);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        sb_q.push_back(mk_exp(32'h3F800000, 1, 3'b000));
        send(32'h3F800000, 0, 1);
        chk("after_stall_latency", {31'h0, out_valid}, 32'h1);

        // Reset mid-frame discards the partial sum.
        @(negedge clk);
        send(32'h40400000, 0, 0);
        send(32'h40800000, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midreset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("midreset_out_data", out_data, 32'h0);
        chk("midreset_out_count", {16'h0, out_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb_q.push_back(mk_exp(32'h40800000, 1, 3'b000));
        send(32'h40800000, 0, 1);
        chk("after_reset_latency", {31'h0, out_valid}, 32'h1);

        // 19 beats of +0 into the 4-bit-count instance.
        @(negedge clk);
        chk("sat_in_ready", {31'h0, in_ready2}, 32'h1);
        for (int k = 0; k < 19; k++) begin
            in_valid2 = 1'b1; in_data2 = 32'h0; in_last2 = (k == 18);
            @(negedge clk);
        end
        in_valid2 = 1'b0; in_last2 = 1'b0;
        chk("sat_out_valid", {31'h0, out_valid2}, 32'h1);
        chk("sat_out_count", {28'h0, out_count2}, 32'hF);
        chk("sat_out_data", out_data2, 32'h0);
        chk("sat_flags", {29'h0, uf2, of2, inv2}, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
